// File: rtl/imem_block.sv
// Instruction memory for the single-cycle core: combinational fetch gated by an
// IDLE/LOAD/RUN FSM, filled through a valid/ready loader with an auto-incrementing pointer.
module imem_block #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0013,
  parameter bit          SKIP_LOAD = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                rd_addr,
  output logic [31:0]                instr,
  output logic                       instr_valid,
  output logic                       addr_fault,
  input  logic                       ld_start,
  input  logic                       ld_valid,
  input  logic [31:0]                ld_data,
  input  logic                       ld_last,
  output logic                       ld_ready,
  output logic                       ld_done,
  output logic [$clog2(DEPTH):0]     ld_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]     ld_count_q, ld_count_d;
  logic            ld_done_q, ld_done_d;
  logic            wr_en;
  logic [31:0]     mem [DEPTH];

  logic            addr_ge_base;
  logic [31:0]     offset;
  logic [31:0]     word_idx;
  logic            fetch_fault;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    ld_count_d = ld_count_q;
    ld_done_d  = 1'b0;
    wr_en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ld_start) begin
          state_d    = LOAD;
          wr_ptr_d   = '0;
          ld_count_d = '0;
        end
      end
      LOAD: begin
        // A restart wins over a word offered in the same cycle.
        if (ld_start) begin
          wr_ptr_d   = '0;
          ld_count_d = '0;
        end else if (ld_valid) begin
          wr_en      = 1'b1;
          wr_ptr_d   = wr_ptr_q + 1'b1;
          ld_count_d = ld_count_q + 1'b1;
          if (ld_last || (wr_ptr_q == AW'(DEPTH - 1))) begin
            state_d   = RUN;
            ld_done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (ld_start) begin
          state_d    = LOAD;
          wr_ptr_d   = '0;
          ld_count_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SKIP_LOAD ? RUN : IDLE;
      wr_ptr_q   <= '0;
      ld_count_q <= '0;
      ld_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      ld_count_q <= ld_count_d;
      ld_done_q  <= ld_done_d;
    end
  end

  // Array has no reset; only a real handshake outside reset may write it.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[wr_ptr_q] <= ld_data;
    end
  end

  always_comb begin
    addr_ge_base = (rd_addr >= BASE_ADDR);
    offset       = addr_ge_base ? (rd_addr - BASE_ADDR) : 32'h0;
    word_idx     = offset >> 2;
    fetch_fault  = (rd_addr[1:0] != 2'b00) || !addr_ge_base || (word_idx >= DEPTH);
  end

  always_comb begin
    instr       = NOP_WORD;
    instr_valid = 1'b0;
    addr_fault  = 1'b0;
    if (state_q == RUN) begin
      if (fetch_fault) begin
        addr_fault = 1'b1;
      end else begin
        instr       = mem[word_idx[AW-1:0]];
        instr_valid = 1'b1;
      end
    end
  end

  assign ld_ready = (state_q == LOAD);
  assign ld_done  = ld_done_q;
  assign ld_count = ld_count_q;

endmodule

// File: doc/imem_block.md
Name: imem_block

Overview:
Instruction memory for the single-cycle core. It takes the fetch address from pc_block (curr_addr) and returns the instruction word combinationally, in the same cycle. A sequential loader port fills the memory with a program before execution, using a valid/ready handshake and an auto-incrementing write pointer. A small FSM gates fetch, so the core executes NOPs until a program is loaded.

Parameters:
DEPTH, 256, number of 32-bit words (power of 2, at least 4)
BASE_ADDR, 32'h00000000, byte address of word 0 (word-aligned)
NOP_WORD, 32'h00000013, word returned when fetch is disabled or faulted (addi x0,x0,0)
SKIP_LOAD, 0, if 1, reset enters RUN directly (for contents preloaded by simulation)

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous, active-high reset
rd_addr  in  32  byte fetch address, driven by pc_block curr_addr
instr  out  32  fetched instruction (combinational from rd_addr and state)
instr_valid  out  1  1 only in RUN with no fault
addr_fault  out  1  RUN and (misaligned or out of range)
ld_start  in  1  begin or restart a program load
ld_valid  in  1  loader word present
ld_data  in  32  loader word
ld_last  in  1  qualifies the final word of the program (sampled with ld_valid)
ld_ready  out  1  memory accepts a word this cycle
ld_done  out  1  one-cycle pulse when a load completes
ld_count  out  $clog2(DEPTH)+1  number of words written by the last or current load

Behaviour:
- States: IDLE, LOAD, RUN. The state is registered.
- Reset with SKIP_LOAD=0 goes to IDLE. With SKIP_LOAD=1 it goes to RUN.
- Reset clears wr_ptr and ld_count to 0 and ld_done to 0. Memory array contents are not reset.
- Fetch (combinational):
  - idx = (rd_addr - BASE_ADDR) >> 2.
  - fault = (rd_addr[1:0] != 0) or (rd_addr < BASE_ADDR) or (idx >= DEPTH).
  - In RUN with no fault: instr = mem[idx], instr_valid=1, addr_fault=0.
  - In RUN with a fault: instr = NOP_WORD, instr_valid=0, addr_fault=1.
  - In IDLE or LOAD: instr = NOP_WORD, instr_valid=0, addr_fault=0.
- IDLE:
  - ld_ready=0.
  - ld_start moves to LOAD at the next edge, with wr_ptr and ld_count set to 0.
- LOAD:
  - ld_ready=1 (purely a function of state).
  - On an edge with ld_valid & ld_ready: mem[wr_ptr] <= ld_data, wr_ptr and ld_count increment.
  - Leave to RUN on the edge that accepts a word with ld_last=1, or the word at wr_ptr=DEPTH-1 (memory full). ld_done=1 for exactly the following cycle.
  - ld_ready is therefore 0 from the first RUN cycle. There is no wrap-around and no write past DEPTH-1.
  - ld_start in LOAD restarts: wr_ptr and ld_count go to 0. A ld_valid in the same cycle is ignored (no write). ld_start has priority.
  - ld_valid=0 holds all state. There is no timeout.
- RUN:
  - ld_start moves to LOAD (reload) and zeroes wr_ptr and ld_count.
  - Fetch is disabled from the LOAD cycle onward.
- ld_count holds its final value after a load until the next ld_start or reset.
- Reset mid-load returns to IDLE (not RUN, even if words were written) with ld_count=0. Partially written words remain in the array.
- ld_data is don't-care when ld_valid=0. X on ld_data must not corrupt memory when there is no handshake.
- All arithmetic is 32-bit unsigned. The subtraction in idx is evaluated only when rd_addr >= BASE_ADDR.

Test Plan:
1. Reset check (DEPTH=4, BASE=0). Stimulus: rst=1 for 2 cycles, then rd_addr=32'h0. Required: instr=32'h00000013, instr_valid=0, ld_ready=0, ld_count=0.
2. Load with ld_last. Stimulus: ld_start, then words 32'h00500093, 32'h00a00113, 32'h002081b3, the last with ld_last=1. Required: ld_done pulses one cycle after the third accept and ld_count=3. Then rd_addr=32'h8 gives instr=32'h002081b3, instr_valid=1.
3. Full stop plus stall. Stimulus: load 4 words with no ld_last, with ld_valid=0 gaps in between. Required: auto-exit to RUN after the 4th accept, ld_ready=0 afterwards, and a 5th word is not written (mem[0] is unchanged).
4. Faults. Stimulus: in RUN, rd_addr=32'h2, then 32'h10 (idx 4 with DEPTH 4). Required: addr_fault=1, instr_valid=0 and instr=32'h00000013 for both. Then rd_addr=32'h4 clears the fault.
5. Restart and reset during load. Stimulus:
   - ld_start together with ld_valid mid-load. Required: ld_count=0 and no write.
   - rst after 2 words. Required: state IDLE, fetch returns NOP, ld_count=0.
6. Reload from RUN. Stimulus: ld_start while rd_addr=32'h0. Required: instr_valid drops from the next cycle. The new words replace the old ones. RUN resumes with the new contents.
